// File: rtl/adc_block_averager_if.sv
// Handshake bundle between the ADC sample stream, the block averager
// and its result consumer. master = stimulus/consumer side, slave = averager.
// Signals: ipData/ipValid/ipClear sample stream, opData/opMin/opMax/opValid
// result, ipReady accept, opOverrun/ipOverrunClr sticky overrun flag.
interface adc_block_averager_if #(
  parameter int DATA_WIDTH = 14
);
  logic [DATA_WIDTH-1:0] ipData;
  logic                  ipValid;
  logic                  ipClear;
  logic [DATA_WIDTH-1:0] opData;
  logic [DATA_WIDTH-1:0] opMin;
  logic [DATA_WIDTH-1:0] opMax;
  logic                  opValid;
  logic                  ipReady;
  logic                  opOverrun;
  logic                  ipOverrunClr;

  modport master (
    output ipData, ipValid, ipClear,
    output ipReady, ipOverrunClr,
    input  opData, opMin, opMax,
    input  opValid, opOverrun
  );

  modport slave (
    input  ipData, ipValid, ipClear,
    input  ipReady, ipOverrunClr,
    output opData, opMin, opMax,
    output opValid, opOverrun
  );
endinterface

// File: rtl/adc_block_averager.sv
// Block averager: rounded mean, min and max over 2^LOG2_N unsigned samples.
// Ports: ipClk, ipReset (async, active-high), bus (slave modport) carrying
// the sample stream, the held result with valid/ready and the overrun flag.
module adc_block_averager #(
  parameter int DATA_WIDTH = 14,
  parameter int LOG2_N     = 4
) (
  input  logic ipClk,
  input  logic ipReset,
  adc_block_averager_if.slave bus
);
  localparam int N  = 1 << LOG2_N;
  localparam int CW = (LOG2_N > 0) ? LOG2_N : 1;
  localparam int AW = DATA_WIDTH + LOG2_N;
  localparam logic [AW-1:0] RND = AW'(N / 2);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [AW-1:0]         acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mn_q, mn_d;
  logic [DATA_WIDTH-1:0] mx_q, mx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] min_q, min_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic                  vld_q, vld_d;
  logic                  ovr_q, ovr_d;

  logic [AW-1:0]         acc_sum;
  logic [AW-1:0]         rnd_sum;
  logic [DATA_WIDTH-1:0] smp_mn;
  logic [DATA_WIDTH-1:0] smp_mx;
  logic                  take;
  logic                  done;

  // Sums include the current sample so the completing
  // sample is part of its own block's result.
  assign acc_sum = acc_q + AW'(bus.ipData);
  assign rnd_sum = acc_sum + RND;
  assign smp_mn  = (bus.ipData < mn_q) ? bus.ipData : mn_q;
  assign smp_mx  = (bus.ipData > mx_q) ? bus.ipData : mx_q;
  assign take    = bus.ipValid & ~bus.ipClear;
  assign done    = take & (cnt_q == LAST);

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    mn_d   = mn_q;
    mx_d   = mx_q;
    data_d = data_q;
    min_d  = min_q;
    max_d  = max_q;
    vld_d  = vld_q;
    ovr_d  = ovr_q;

    if (bus.ipClear || done) begin
      acc_d = '0;
      cnt_d = '0;
      mn_d  = '1;
      mx_d  = '0;
    end else if (take) begin
      acc_d = acc_sum;
      cnt_d = cnt_q + CW'(1);
      mn_d  = smp_mn;
      mx_d  = smp_mx;
    end

    if (bus.ipOverrunClr) ovr_d = 1'b0;

    if (done) begin
      data_d = DATA_WIDTH'(rnd_sum >> LOG2_N);
      min_d  = smp_mn;
      max_d  = smp_mx;
      vld_d  = 1'b1;
      // A new result over an unread one sets the
      // flag; the set beats a same-cycle clear.
      if (vld_q && !bus.ipReady) ovr_d = 1'b1;
    end else if (vld_q && bus.ipReady) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      mn_q   <= '1;
      mx_q   <= '0;
      data_q <= '0;
      min_q  <= '0;
      max_q  <= '0;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      mn_q   <= mn_d;
      mx_q   <= mx_d;
      data_q <= data_d;
      min_q  <= min_d;
      max_q  <= max_d;
      vld_q  <= vld_d;
      ovr_q  <= ovr_d;
    end
  end

  assign bus.opData    = data_q;
  assign bus.opMin     = min_q;
  assign bus.opMax     = max_q;
  assign bus.opValid   = vld_q;
  assign bus.opOverrun = ovr_q;
endmodule
